// File: rtl/jtcop_sdram_resp.sv
// Bank-request responder: arbitrates the four game banks and the ROM downloader,
// then runs one access at a time against a fixed-latency 16-bit memory port.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ba0..3_addr, ba_rd, ba_wr  bank requests (write on bank 0 only)
//   ba0_din, ba0_din_m         bank 0 write data / mask (1 = byte kept)
//   ba_ack/dst/dok/rdy         per-bank accept, first word, word valid, complete
//   data_read                  shared read data
//   downloading, prog_*        ROM downloader requests and handshakes
//   mem_*                      fixed-latency memory port
module jtcop_sdram_resp #(
  parameter int unsigned BURST   = 2,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [21:0] ba0_addr,
  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  input  logic [3:0]  ba_rd,
  input  logic        ba_wr,
  input  logic [15:0] ba0_din,
  input  logic [1:0]  ba0_din_m,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_dst,
  output logic [3:0]  ba_dok,
  output logic [3:0]  ba_rdy,
  output logic [15:0] data_read,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [1:0]  prog_ba,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  input  logic        prog_rd,
  output logic        prog_ack,
  output logic        prog_rdy,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_mask,
  input  logic [15:0] mem_dout
);

  localparam int unsigned AW = 22;
  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        bank_q, bank_d, rr_q, rr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              wr_q, wr_d, prog_q, prog_d;
  logic [CW-1:0]     icnt_q, icnt_d, rcnt_q, rcnt_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;

  logic [3:0]  ack_d, dst_d, dok_d, rdy_d;
  logic [15:0] data_d, mdin_d;
  logic [23:0] maddr_d;
  logic [1:0]  mmask_d;
  logic        pack_d, prdy_d, mrd_d, mwr_d, take;

  logic [3:0]    req;
  logic [1:0]    gnt, cand;
  logic          found;
  logic [AW-1:0] gnt_addr;

  // Round-robin pick, searching from the bank after the last grant
  always_comb begin
    req   = {ba_rd[3:1], ba_rd[0] | ba_wr};
    found = 1'b0;
    gnt   = rr_q;
    cand  = rr_q;
    for (int i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  always_comb begin
    case (gnt)
      2'd0:    gnt_addr = ba0_addr;
      2'd1:    gnt_addr = ba1_addr;
      2'd2:    gnt_addr = ba2_addr;
      default: gnt_addr = ba3_addr;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    prog_d  = prog_q;
    icnt_d  = icnt_q;
    rcnt_d  = rcnt_q;
    vld_d   = MEM_LAT'({vld_q, mem_rd});  // marks which cycles carry valid mem_dout
    ack_d   = '0;
    dst_d   = '0;
    dok_d   = '0;
    rdy_d   = '0;
    pack_d  = 1'b0;
    prdy_d  = 1'b0;
    mrd_d   = 1'b0;
    mwr_d   = 1'b0;
    data_d  = data_read;
    maddr_d = mem_addr;
    mdin_d  = mem_din;
    mmask_d = mem_mask;
    take    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rcnt_d = '0;
        if (downloading) begin
          // Bank requests wait while the downloader owns the memory
          if (prog_we || prog_rd) begin
            take    = 1'b1;
            prog_d  = 1'b1;
            wr_d    = prog_we;
            bank_d  = prog_ba;
            addr_d  = prog_addr;
            pack_d  = 1'b1;
            mdin_d  = prog_data;
            mmask_d = prog_mask;
          end
        end else if (found) begin
          take    = 1'b1;
          prog_d  = 1'b0;
          wr_d    = (gnt == 2'd0) && ba_wr;
          bank_d  = gnt;
          addr_d  = gnt_addr;
          rr_d    = gnt + 2'd1;
          ack_d[gnt] = 1'b1;
          mdin_d  = ba0_din;
          mmask_d = ba0_din_m;
        end
        if (take) begin
          state_d = ST_ISSUE;
          maddr_d = {bank_d, addr_d};
          if (wr_d) begin
            mwr_d = 1'b1;
          end else begin
            mrd_d  = 1'b1;
            icnt_d = CW'(1);
          end
        end
      end
      ST_ISSUE: begin
        if (wr_q) begin
          state_d = ST_DONE;
          if (prog_q) prdy_d = 1'b1;
          else        rdy_d[bank_q] = 1'b1;
        end else if (icnt_q < CW'(BURST)) begin
          // Word address wraps inside the 22-bit bank space
          mrd_d   = 1'b1;
          maddr_d = {bank_q, addr_q + AW'(icnt_q)};
          icnt_d  = icnt_q + CW'(1);
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Read data return; may overlap ISSUE for short latencies
    if (vld_q[MEM_LAT-1]) begin
      data_d = mem_dout;
      rcnt_d = rcnt_q + CW'(1);
      if (!prog_q) begin
        dok_d[bank_q] = 1'b1;
        if (rcnt_q == '0) dst_d[bank_q] = 1'b1;
      end
      if (rcnt_q == CW'(BURST - 1)) begin
        state_d = ST_DONE;
        if (prog_q) prdy_d = 1'b1;
        else        rdy_d[bank_q] = 1'b1;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bank_q    <= '0;
      rr_q      <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      prog_q    <= 1'b0;
      icnt_q    <= '0;
      rcnt_q    <= '0;
      vld_q     <= '0;
      ba_ack    <= '0;
      ba_dst    <= '0;
      ba_dok    <= '0;
      ba_rdy    <= '0;
      data_read <= '0;
      prog_ack  <= 1'b0;
      prog_rdy  <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_din   <= '0;
      mem_mask  <= '0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      prog_q    <= prog_d;
      icnt_q    <= icnt_d;
      rcnt_q    <= rcnt_d;
      vld_q     <= vld_d;
      ba_ack    <= ack_d;
      ba_dst    <= dst_d;
      ba_dok    <= dok_d;
      ba_rdy    <= rdy_d;
      data_read <= data_d;
      prog_ack  <= pack_d;
      prog_rdy  <= prdy_d;
      mem_addr  <= maddr_d;
      mem_rd    <= mrd_d;
      mem_wr    <= mwr_d;
      mem_din   <= mdin_d;
      mem_mask  <= mmask_d;
    end
  end

endmodule

// File: tb/tb_jtcop_sdram_resp.sv
// Randomized scoreboard bench for jtcop_sdram_resp with a cycle-timed reference model.
module tb_jtcop_sdram_resp;
  localparam int B = 2;
  localparam int L = 2;

  logic        clk, rst_n;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]  ba_rd, ba_ack, ba_dst, ba_dok, ba_rdy;
  logic        ba_wr, downloading, prog_we, prog_rd, prog_ack, prog_rdy;
  logic [15:0] ba0_din, data_read, prog_data, mem_din, mem_dout;
  logic [1:0]  ba0_din_m, prog_ba, prog_mask, mem_mask;
  logic [21:0] prog_addr;
  logic [23:0] mem_addr;
  logic        mem_rd, mem_wr;

  jtcop_sdram_resp #(.BURST(B), .MEM_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .data_read(data_read), .downloading(downloading),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_rd(prog_rd), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
    .mem_mask(mem_mask), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Expected strobes and data for one cycle
  typedef struct packed {
    logic [3:0]  ack, dst, dok, rdy;
    logic        pack, prdy, rd, wr, chk;
    logic [15:0] data;
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  mask;
  } exp_t;
  exp_t sb[int];

  logic [15:0] dev_mem[int];
  logic [15:0] ref_mem[int];

  function automatic logic [15:0] init_val(int a);
    int unsigned h;
    h = int'(a) * 32'd2654435761;
    return h[31:16];
  endfunction

  function automatic logic [15:0] dev_rd(int a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] mrg(logic [15:0] old, logic [15:0] d, logic [1:0] m);
    logic [15:0] r;
    r = old;
    if (!m[0]) r[7:0]  = d[7:0];
    if (!m[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  function automatic int baddr(int b, int a);
    return b * (1 << 22) + (a % (1 << 22));
  endfunction

  function automatic exp_t get_e(int c);
    exp_t e;
    e = '0;
    if (sb.exists(c)) e = sb[c];
    return e;
  endfunction

  // Fixed-latency memory device
  logic [15:0] dpipe [L];
  assign mem_dout = dpipe[L-1];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
    dpipe[0] <= mem_rd ? dev_rd(int'(mem_addr)) : 16'hDEAD;
  end
  always @(negedge clk) begin
    if (mem_wr) dev_mem[int'(mem_addr)] = mrg(dev_rd(int'(mem_addr)), mem_din, mem_mask);
  end

  // Monitor: compare every cycle that has an expected or observed strobe
  exp_t       me;
  logic [19:0] ov, ev;
  logic       bad;
  always @(negedge clk) begin
    me = get_e(cyc);
    ov = {ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_rdy, mem_rd, mem_wr};
    ev = {me.ack, me.dst, me.dok, me.rdy, me.pack, me.prdy, me.rd, me.wr};
    if (ov != 20'd0 || ev != 20'd0) begin
      checks++;
      bad = (ov != ev) || ((me.rd || me.wr) && mem_addr != me.addr) ||
            (me.wr && (mem_din != me.din || mem_mask != me.mask)) ||
            (me.chk && data_read != me.data);
      if (bad) begin
        errors++;
        $display("FAIL trace cyc=%0d got strobes=%h addr=%h din=%h mask=%b data=%h want strobes=%h addr=%h din=%h mask=%b data=%h",
                 cyc, ov, mem_addr, mem_din, mem_mask, data_read, ev, me.addr, me.din, me.mask, me.data);
      end
    end
    if (sb.exists(cyc)) sb.delete(cyc);
  end

  // Reference model state
  int          rr = 0;
  int          nxt = 0;
  logic [15:0] last_data = 16'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sched_read(int b, int a, int s, bit pg, output int t_end);
    exp_t e;
    int ad;
    logic [15:0] w;
    e = get_e(s + 1);
    if (pg) e.pack = 1'b1; else e.ack[b] = 1'b1;
    sb[s + 1] = e;
    for (int k = 0; k < B; k++) begin
      ad = baddr(b, a + k);
      e = get_e(s + 1 + k);
      e.rd = 1'b1;
      e.addr = 24'(ad);
      sb[s + 1 + k] = e;
      w = ref_rd(ad);
      e = get_e(s + 2 + L + k);
      if (!pg) begin
        e.dok[b] = 1'b1;
        if (k == 0) e.dst[b] = 1'b1;
        if (k == B - 1) e.rdy[b] = 1'b1;
        e.chk = 1'b1;
        e.data = w;
      end else if (k == B - 1) begin
        e.prdy = 1'b1;
        e.chk = 1'b1;
        e.data = w;
      end
      sb[s + 2 + L + k] = e;
      last_data = w;
    end
    t_end = s + 2 + L + B;
  endtask

  task automatic sched_write(int b, int a, logic [15:0] d, logic [1:0] m, int s, bit pg, output int t_end);
    exp_t e;
    int ad;
    ad = baddr(b, a);
    e = get_e(s + 1);
    if (pg) e.pack = 1'b1; else e.ack[b] = 1'b1;
    e.wr = 1'b1;
    e.addr = 24'(ad);
    e.din = d;
    e.mask = m;
    sb[s + 1] = e;
    e = get_e(s + 2);
    if (pg) e.prdy = 1'b1; else e.rdy[b] = 1'b1;
    sb[s + 2] = e;
    ref_mem[ad] = mrg(ref_rd(ad), d, m);
    t_end = s + 3;
  endtask

  // One batch: bank reads in mask m (bank 0 a write if wr0), optional download op first
  task automatic run_batch(logic [3:0] m, bit wr0, int dl, int pb, int pa,
                           logic [15:0] pd, logic [1:0] pm, input int ad[4],
                           logic [15:0] d0, logic [1:0] m0);
    int s, t, t2, dl_end, g;
    int gc[4];
    logic [3:0] pend;
    while (cyc < nxt) tick();
    s = cyc;
    t = s;
    dl_end = -1;
    if (dl == 1) begin sched_write(pb, pa, pd, pm, t, 1'b1, t2); t = t2; end
    if (dl == 2) begin sched_read(pb, pa, t, 1'b1, t2); t = t2; end
    if (dl != 0) dl_end = t;
    for (int i = 0; i < 4; i++) gc[i] = -1;
    pend = m;
    while (pend != 4'd0) begin
      g = -1;
      for (int i = 0; i < 4; i++) if (g < 0 && pend[(rr + i) % 4]) g = (rr + i) % 4;
      if (g == 0 && wr0) sched_write(0, ad[0], d0, m0, t, 1'b0, t2);
      else sched_read(g, ad[g], t, 1'b0, t2);
      gc[g] = t;
      t = t2;
      rr = (g + 1) % 4;
      pend[g] = 1'b0;
    end
    nxt = t;
    ba0_addr = 22'(ad[0]); ba1_addr = 22'(ad[1]); ba2_addr = 22'(ad[2]); ba3_addr = 22'(ad[3]);
    ba_rd = m; ba_wr = wr0; ba0_din = d0; ba0_din_m = m0;
    downloading = (dl != 0); prog_we = (dl == 1); prog_rd = (dl == 2);
    prog_ba = 2'(pb); prog_addr = 22'(pa); prog_data = pd; prog_mask = pm;
    while (cyc < nxt) begin
      tick();
      if (cyc == s + 1) begin prog_we = 1'b0; prog_rd = 1'b0; end
      if (cyc == dl_end) downloading = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (gc[b] >= 0 && cyc == gc[b] + 1) begin
          ba_rd[b] = 1'b0;
          if (b == 0) ba_wr = 1'b0;
        end
      end
    end
  endtask

  task automatic chk_zero(string nm);
    checks++;
    if ({ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_ack, prog_rdy,
         mem_addr, mem_rd, mem_wr, mem_din, mem_mask} != 0) begin
      errors++;
      $display("FAIL %s got ack=%h dst=%h dok=%h rdy=%h data=%h pack=%b prdy=%b addr=%h rd=%b wr=%b din=%h mask=%b want all zero",
               nm, ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_ack, prog_rdy,
               mem_addr, mem_rd, mem_wr, mem_din, mem_mask);
    end
  endtask

  function automatic int rnd_addr();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 7));
      1:       return 32'h3FFFFF - int'($urandom_range(0, 1));
      default: return int'($urandom & 32'h3FFFFF);
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ad[4];
    int s, t2, dl, r;
    logic [3:0] m;
    rst_n = 1'b0;
    ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
    ba_rd = '0; ba_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
    downloading = 1'b0; prog_addr = '0; prog_ba = '0; prog_data = '0;
    prog_mask = '0; prog_we = 1'b0; prog_rd = 1'b0;
    tick(); tick(); tick();
    chk_zero("reset_state");
    rst_n = 1'b1;
    nxt = cyc + 1;

    // Single read, bank 2
    dev_mem[baddr(2, 'h100000)] = 16'h1234; ref_mem[baddr(2, 'h100000)] = 16'h1234;
    dev_mem[baddr(2, 'h100001)] = 16'h5678; ref_mem[baddr(2, 'h100001)] = 16'h5678;
    ad = '{0, 0, 'h100000, 0};
    run_batch(4'b0100, 1'b0, 0, 0, 0, 16'h0, 2'b00, ad, 16'h0, 2'b00);

    // Masked write then read-back on bank 0
    dev_mem[baddr(0, 'h1234)] = 16'h5A5A; ref_mem[baddr(0, 'h1234)] = 16'h5A5A;
    ad = '{'h1234, 0, 0, 0};
    run_batch(4'b0001, 1'b1, 0, 0, 0, 16'h0, 2'b00, ad, 16'hABCD, 2'b10);
    run_batch(4'b0001, 1'b0, 0, 0, 0, 16'h0, 2'b00, ad, 16'h0, 2'b00);

    // Round-robin with all banks requesting
    ad = '{'h10, 'h20, 'h30, 'h40};
    run_batch(4'b1111, 1'b0, 0, 0, 0, 16'h0, 2'b00, ad, 16'h0, 2'b00);

    // Address wrap at the top of bank 1
    ad = '{0, 'h3FFFFF, 0, 0};
    run_batch(4'b0010, 1'b0, 0, 0, 0, 16'h0, 2'b00, ad, 16'h0, 2'b00);

    // Download write while bank 3 waits
    ad = '{0, 0, 0, 'h77};
    run_batch(4'b1000, 1'b0, 1, 3, 'h40000, 16'hBEEF, 2'b00, ad, 16'h0, 2'b00);

    // Reset in the middle of a bank 1 read
    while (cyc < nxt) tick();
    s = cyc;
    sched_read(1, 'h1234, s, 1'b0, t2);
    ba1_addr = 22'h1234; ba_rd = 4'b0010;
    tick(); ba_rd = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid_read");
    for (int c = s + 3; c < s + 12; c++) if (sb.exists(c)) sb.delete(c);
    last_data = 16'h0;
    rr = 0;
    tick(); tick();
    rst_n = 1'b1;
    nxt = cyc + 1;
    ad = '{'h55, 'h66, 0, 0};
    run_batch(4'b0011, 1'b0, 0, 0, 0, 16'h0, 2'b00, ad, 16'h0, 2'b00);

    // Randomized batches
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 5));
      dl = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      m = 4'($urandom_range(0, 15));
      if (dl == 0 && m == 4'd0) m = 4'd1;
      for (int i = 0; i < 4; i++) ad[i] = rnd_addr();
      run_batch(m, m[0] && ($urandom_range(0, 1) == 1), dl, int'($urandom_range(0, 3)), rnd_addr(),
                16'($urandom), 2'($urandom), ad, 16'($urandom), 2'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      if (nxt < cyc) nxt = cyc;
    end

    while (cyc < nxt + 8) tick();
    checks++;
    if (data_read !== last_data) begin
      errors++;
      $display("FAIL data_hold got %h want %h", data_read, last_data);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
